// File: rtl/pms_axi_id_remap.sv
// AXI ID remapper: compresses wide upstream IDs onto a small table of downstream IDs, one table per direction.
// Optional sticky unexpected-response detection is built only when PMS_ID_REMAP_ERR_EN is defined.
module pms_axi_id_remap #(
  parameter int unsigned InpIdWidth   = 7,
  parameter int unsigned OupIdWidth   = 6,
  parameter int unsigned MaxUniqIds   = 8,
  parameter int unsigned MaxTxnsPerId = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  slv_aw_valid_i,
  output logic                  slv_aw_ready_o,
  input  logic [InpIdWidth-1:0] slv_aw_id_i,
  output logic                  mst_aw_valid_o,
  input  logic                  mst_aw_ready_i,
  output logic [OupIdWidth-1:0] mst_aw_id_o,
  input  logic                  mst_b_valid_i,
  output logic                  mst_b_ready_o,
  input  logic [OupIdWidth-1:0] mst_b_id_i,
  output logic                  slv_b_valid_o,
  input  logic                  slv_b_ready_i,
  output logic [InpIdWidth-1:0] slv_b_id_o,
  input  logic                  slv_ar_valid_i,
  output logic                  slv_ar_ready_o,
  input  logic [InpIdWidth-1:0] slv_ar_id_i,
  output logic                  mst_ar_valid_o,
  input  logic                  mst_ar_ready_i,
  output logic [OupIdWidth-1:0] mst_ar_id_o,
  input  logic                  mst_r_valid_i,
  output logic                  mst_r_ready_o,
  input  logic [OupIdWidth-1:0] mst_r_id_i,
  input  logic                  mst_r_last_i,
  output logic                  slv_r_valid_o,
  input  logic                  slv_r_ready_i,
  output logic [InpIdWidth-1:0] slv_r_id_o,
  output logic                  err_o
);

  localparam int unsigned IdxW = (MaxUniqIds > 1) ? $clog2(MaxUniqIds) : 1;
  localparam int unsigned CntW = $clog2(MaxTxnsPerId + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxnsPerId);
  localparam logic [CntW-1:0] OneCnt = CntW'(1);
  localparam logic [OupIdWidth:0] NumIds = (OupIdWidth + 1)'(MaxUniqIds);

  // Index 0 is the write direction (AW/B), index 1 the read direction (AR/R).
  logic                  valid_r [2][MaxUniqIds];
  logic [InpIdWidth-1:0] id_r    [2][MaxUniqIds];
  logic [CntW-1:0]       cnt_r   [2][MaxUniqIds];

  logic                  alloc_s [2][MaxUniqIds];
  logic                  dec_s   [2][MaxUniqIds];

  logic [1:0]            req_valid_s, req_ready_s, req_hs_s, map_ok_s;
  logic [1:0]            hit_s, free_s;
  logic [InpIdWidth-1:0] req_id_s   [2];
  logic [IdxW-1:0]       hit_idx_s  [2];
  logic [IdxW-1:0]       free_idx_s [2];
  logic [IdxW-1:0]       map_idx_s  [2];

  logic [1:0]            rsp_valid_s, rsp_ready_s, rsp_last_s;
  logic [1:0]            rsp_in_range_s, rsp_hit_s, rsp_dec_s;
  logic [OupIdWidth-1:0] rsp_id_s     [2];
  logic [IdxW-1:0]       rsp_idx_s    [2];
  logic [InpIdWidth-1:0] rsp_id_out_s [2];

  assign req_valid_s = {slv_ar_valid_i, slv_aw_valid_i};
  assign req_ready_s = {mst_ar_ready_i, mst_aw_ready_i};
  assign req_id_s[0] = slv_aw_id_i;
  assign req_id_s[1] = slv_ar_id_i;
  assign rsp_valid_s = {mst_r_valid_i, mst_b_valid_i};
  assign rsp_ready_s = {slv_r_ready_i, slv_b_ready_i};
  assign rsp_last_s  = {mst_r_last_i, 1'b1};
  assign rsp_id_s[0] = mst_b_id_i;
  assign rsp_id_s[1] = mst_r_id_i;

  assign mst_aw_valid_o = slv_aw_valid_i & map_ok_s[0];
  assign slv_aw_ready_o = mst_aw_ready_i & map_ok_s[0];
  assign mst_aw_id_o    = OupIdWidth'(map_idx_s[0]);
  assign mst_ar_valid_o = slv_ar_valid_i & map_ok_s[1];
  assign slv_ar_ready_o = mst_ar_ready_i & map_ok_s[1];
  assign mst_ar_id_o    = OupIdWidth'(map_idx_s[1]);

  assign slv_b_valid_o = mst_b_valid_i;
  assign mst_b_ready_o = slv_b_ready_i;
  assign slv_b_id_o    = rsp_id_out_s[0];
  assign slv_r_valid_o = mst_r_valid_i;
  assign mst_r_ready_o = slv_r_ready_i;
  assign slv_r_id_o    = rsp_id_out_s[1];

  // Request lookup: descending scans leave the lowest matching / lowest free index.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      hit_s[d]      = 1'b0;
      free_s[d]     = 1'b0;
      hit_idx_s[d]  = {IdxW{1'b0}};
      free_idx_s[d] = {IdxW{1'b0}};
      for (int i = int'(MaxUniqIds) - 1; i >= 0; i--) begin
        hit_s[d]      = (valid_r[d][i] && (id_r[d][i] == req_id_s[d])) ? 1'b1 : hit_s[d];
        hit_idx_s[d]  = (valid_r[d][i] && (id_r[d][i] == req_id_s[d])) ? IdxW'(i) : hit_idx_s[d];
        free_s[d]     = !valid_r[d][i] ? 1'b1 : free_s[d];
        free_idx_s[d] = !valid_r[d][i] ? IdxW'(i) : free_idx_s[d];
      end
      map_ok_s[d]  = hit_s[d] ? (cnt_r[d][hit_idx_s[d]] < MaxCnt) : free_s[d];
      map_idx_s[d] = hit_s[d] ? hit_idx_s[d] : free_idx_s[d];
      req_hs_s[d]  = req_valid_s[d] & req_ready_s[d] & map_ok_s[d];
    end
  end

  // Response lookup: out-of-range or invalid entries are forwarded but never retire a transaction.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      rsp_in_range_s[d] = ({1'b0, rsp_id_s[d]} < NumIds);
      rsp_idx_s[d]      = rsp_id_s[d][IdxW-1:0];
      rsp_hit_s[d]      = rsp_in_range_s[d] & valid_r[d][rsp_idx_s[d]];
      rsp_id_out_s[d]   = rsp_in_range_s[d] ? id_r[d][rsp_idx_s[d]] : {InpIdWidth{1'b0}};
      rsp_dec_s[d]      = rsp_valid_s[d] & rsp_ready_s[d] & rsp_last_s[d] & rsp_hit_s[d];
    end
  end

  // Per-entry allocate / retire strobes.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < MaxUniqIds; i++) begin
        alloc_s[d][i] = req_hs_s[d] && (map_idx_s[d] == IdxW'(i));
        dec_s[d][i]   = rsp_dec_s[d] && (rsp_idx_s[d] == IdxW'(i));
      end
    end
  end

  // Table update; a simultaneous allocate and retire on one entry cancel out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < MaxUniqIds; i++) begin
          valid_r[d][i] <= 1'b0;
          id_r[d][i]    <= {InpIdWidth{1'b0}};
          cnt_r[d][i]   <= {CntW{1'b0}};
        end
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < MaxUniqIds; i++) begin
          case ({alloc_s[d][i], dec_s[d][i]})
            2'b10: begin
              valid_r[d][i] <= 1'b1;
              id_r[d][i]    <= req_id_s[d];
              cnt_r[d][i]   <= cnt_r[d][i] + OneCnt;
            end
            2'b01: begin
              valid_r[d][i] <= (cnt_r[d][i] != OneCnt);
              id_r[d][i]    <= id_r[d][i];
              cnt_r[d][i]   <= cnt_r[d][i] - OneCnt;
            end
            2'b11: begin
              valid_r[d][i] <= 1'b1;
              id_r[d][i]    <= req_id_s[d];
              cnt_r[d][i]   <= cnt_r[d][i];
            end
            default: begin
              valid_r[d][i] <= valid_r[d][i];
              id_r[d][i]    <= id_r[d][i];
              cnt_r[d][i]   <= cnt_r[d][i];
            end
          endcase
        end
      end
    end
  end

`ifdef PMS_ID_REMAP_ERR_EN
  logic unexp_s;
  logic err_r;

  assign unexp_s = (mst_b_valid_i & slv_b_ready_i & ~rsp_hit_s[0]) |
                   (mst_r_valid_i & slv_r_ready_i & ~rsp_hit_s[1]);

  // Sticky unexpected-response flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | unexp_s;
    end
  end

  assign err_o = err_r;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pms_axi_id_remap.sv
// Directed bench for pms_axi_id_remap; expected err_o follows PMS_ID_REMAP_ERR_EN.
module tb_pms_axi_id_remap;

`ifdef PMS_ID_REMAP_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       slv_aw_valid, slv_aw_ready, mst_aw_valid, mst_aw_ready;
  logic [6:0] slv_aw_id;
  logic [5:0] mst_aw_id;
  logic       mst_b_valid, mst_b_ready, slv_b_valid, slv_b_ready;
  logic [5:0] mst_b_id;
  logic [6:0] slv_b_id;
  logic       slv_ar_valid, slv_ar_ready, mst_ar_valid, mst_ar_ready;
  logic [6:0] slv_ar_id;
  logic [5:0] mst_ar_id;
  logic       mst_r_valid, mst_r_ready, mst_r_last, slv_r_valid, slv_r_ready;
  logic [5:0] mst_r_id;
  logic [6:0] slv_r_id;
  logic       err;

  int n_vec = 0;
  int n_err = 0;

  pms_axi_id_remap dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_aw_valid_i(slv_aw_valid), .slv_aw_ready_o(slv_aw_ready), .slv_aw_id_i(slv_aw_id),
    .mst_aw_valid_o(mst_aw_valid), .mst_aw_ready_i(mst_aw_ready), .mst_aw_id_o(mst_aw_id),
    .mst_b_valid_i(mst_b_valid), .mst_b_ready_o(mst_b_ready), .mst_b_id_i(mst_b_id),
    .slv_b_valid_o(slv_b_valid), .slv_b_ready_i(slv_b_ready), .slv_b_id_o(slv_b_id),
    .slv_ar_valid_i(slv_ar_valid), .slv_ar_ready_o(slv_ar_ready), .slv_ar_id_i(slv_ar_id),
    .mst_ar_valid_o(mst_ar_valid), .mst_ar_ready_i(mst_ar_ready), .mst_ar_id_o(mst_ar_id),
    .mst_r_valid_i(mst_r_valid), .mst_r_ready_o(mst_r_ready), .mst_r_id_i(mst_r_id),
    .mst_r_last_i(mst_r_last),
    .slv_r_valid_o(slv_r_valid), .slv_r_ready_i(slv_r_ready), .slv_r_id_o(slv_r_id),
    .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [6:0] id, input logic [5:0] exp_oid);
    slv_aw_valid = 1'b1; slv_aw_id = id; mst_aw_ready = 1'b1;
    #1;
    check_val("aw_valid", 32'(mst_aw_valid), 32'd1);
    check_val("aw_ready", 32'(slv_aw_ready), 32'd1);
    check_val("aw_id", 32'(mst_aw_id), 32'(exp_oid));
    tick();
    slv_aw_valid = 1'b0;
  endtask

  task automatic aw_stall(input logic [6:0] id);
    slv_aw_valid = 1'b1; slv_aw_id = id; mst_aw_ready = 1'b1;
    #1;
    check_val("aw_stall_ready", 32'(slv_aw_ready), 32'd0);
    check_val("aw_stall_valid", 32'(mst_aw_valid), 32'd0);
    slv_aw_valid = 1'b0;
    tick();
  endtask

  task automatic aw_probe(input logic [6:0] id, input logic [5:0] exp_oid);
    slv_aw_valid = 1'b1; slv_aw_id = id; mst_aw_ready = 1'b0;
    #1;
    check_val("aw_probe_valid", 32'(mst_aw_valid), 32'd1);
    check_val("aw_probe_id", 32'(mst_aw_id), 32'(exp_oid));
    slv_aw_valid = 1'b0; mst_aw_ready = 1'b1;
    tick();
  endtask

  task automatic b_send(input logic [5:0] oid, input logic [6:0] exp_iid);
    mst_b_valid = 1'b1; mst_b_id = oid; slv_b_ready = 1'b1;
    #1;
    check_val("b_valid", 32'(slv_b_valid), 32'd1);
    check_val("b_ready", 32'(mst_b_ready), 32'd1);
    check_val("b_id", 32'(slv_b_id), 32'(exp_iid));
    tick();
    mst_b_valid = 1'b0;
  endtask

  task automatic ar_send(input logic [6:0] id, input logic [5:0] exp_oid);
    slv_ar_valid = 1'b1; slv_ar_id = id; mst_ar_ready = 1'b1;
    #1;
    check_val("ar_ready", 32'(slv_ar_ready), 32'd1);
    check_val("ar_id", 32'(mst_ar_id), 32'(exp_oid));
    tick();
    slv_ar_valid = 1'b0;
  endtask

  task automatic ar_probe(input logic [6:0] id, input logic [5:0] exp_oid);
    slv_ar_valid = 1'b1; slv_ar_id = id; mst_ar_ready = 1'b0;
    #1;
    check_val("ar_probe_valid", 32'(mst_ar_valid), 32'd1);
    check_val("ar_probe_id", 32'(mst_ar_id), 32'(exp_oid));
    slv_ar_valid = 1'b0; mst_ar_ready = 1'b1;
    tick();
  endtask

  task automatic r_send(input logic [5:0] oid, input logic last, input logic [6:0] exp_iid);
    mst_r_valid = 1'b1; mst_r_id = oid; mst_r_last = last; slv_r_ready = 1'b1;
    #1;
    check_val("r_valid", 32'(slv_r_valid), 32'd1);
    check_val("r_id", 32'(slv_r_id), 32'(exp_iid));
    tick();
    mst_r_valid = 1'b0; mst_r_last = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    slv_aw_valid = 1'b0; slv_aw_id = '0; mst_aw_ready = 1'b0;
    mst_b_valid = 1'b0; mst_b_id = '0; slv_b_ready = 1'b0;
    slv_ar_valid = 1'b0; slv_ar_id = '0; mst_ar_ready = 1'b0;
    mst_r_valid = 1'b0; mst_r_id = '0; mst_r_last = 1'b0; slv_r_ready = 1'b0;
    #12;
    check_val("rst_aw_valid", 32'(mst_aw_valid), 32'd0);
    check_val("rst_ar_valid", 32'(mst_ar_valid), 32'd0);
    check_val("rst_b_valid", 32'(slv_b_valid), 32'd0);
    check_val("rst_r_valid", 32'(slv_r_valid), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    tick();
    rst_n = 1'b1;
    mst_aw_ready = 1'b1; slv_b_ready = 1'b1; mst_ar_ready = 1'b1; slv_r_ready = 1'b1;
    tick();

    // Single write round trip, entry freed afterwards
    aw_send(7'h45, 6'd0);
    b_send(6'd0, 7'h45);
    aw_probe(7'h33, 6'd0);

    // Per-entry limit of four, fifth waits for a retiring B
    for (int k = 0; k < 4; k++) aw_send(7'h10, 6'd0);
    slv_aw_valid = 1'b1; slv_aw_id = 7'h10;
    mst_b_valid = 1'b1; mst_b_id = 6'd0;
    #1;
    check_val("fifth_stall", 32'(slv_aw_ready), 32'd0);
    check_val("fifth_b_id", 32'(slv_b_id), 32'h10);
    tick();
    mst_b_valid = 1'b0;
    #1;
    check_val("fifth_go_ready", 32'(slv_aw_ready), 32'd1);
    check_val("fifth_go_id", 32'(mst_aw_id), 32'd0);
    tick();
    slv_aw_valid = 1'b0;
    aw_stall(7'h10);
    for (int k = 0; k < 4; k++) b_send(6'd0, 7'h10);
    aw_probe(7'h21, 6'd0);

    // Same-cycle allocate and retire on entry 0 with counter 2
    aw_send(7'h10, 6'd0);
    aw_send(7'h10, 6'd0);
    slv_aw_valid = 1'b1; slv_aw_id = 7'h10;
    mst_b_valid = 1'b1; mst_b_id = 6'd0;
    #1;
    check_val("both_aw_ready", 32'(slv_aw_ready), 32'd1);
    check_val("both_aw_id", 32'(mst_aw_id), 32'd0);
    check_val("both_b_id", 32'(slv_b_id), 32'h10);
    tick();
    slv_aw_valid = 1'b0; mst_b_valid = 1'b0;
    aw_send(7'h10, 6'd0);
    aw_send(7'h10, 6'd0);
    aw_stall(7'h10);
    for (int k = 0; k < 4; k++) b_send(6'd0, 7'h10);
    aw_probe(7'h21, 6'd0);

    // Table full with eight distinct IDs
    for (int k = 0; k < 8; k++) aw_send(7'(k), 6'(k));
    aw_stall(7'h7F);
    b_send(6'd3, 7'h03);
    aw_send(7'h7F, 6'd3);
    ar_probe(7'h05, 6'd0);

    // Read burst: entry held until the last beat
    ar_send(7'h22, 6'd0);
    r_send(6'd0, 1'b0, 7'h22);
    ar_probe(7'h44, 6'd1);
    r_send(6'd0, 1'b0, 7'h22);
    r_send(6'd0, 1'b1, 7'h22);
    ar_probe(7'h44, 6'd0);

    // Out-of-range response ID is still forwarded
    mst_b_valid = 1'b1; mst_b_id = 6'h3F; slv_b_ready = 1'b0;
    #1;
    check_val("oor_b_valid", 32'(slv_b_valid), 32'd1);
    mst_b_valid = 1'b0; slv_b_ready = 1'b1;
    tick();

    // Mid-traffic reset drops every mapping
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick();
    aw_probe(7'h01, 6'd0);
    check_val("err_before", 32'(err), 32'd0);

    // Unexpected response on an empty table
    b_send(6'd5, 7'h00);
    check_val("err_set", 32'(err), 32'(ERR_EXP));
    tick();
    check_val("err_held", 32'(err), 32'(ERR_EXP));
    aw_probe(7'h09, 6'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
